// File: rtl/ssrv_perf_mon_if.sv
// Strobe and readback bundle between the ssrv_top event taps and ssrv_perf_mon.
// master = core/bench side driving events and select; slave = the monitor.
interface ssrv_perf_mon_if #(
    parameter int EXEC_LEN = 4,
    parameter int CNT_W    = 32,
    parameter int SEL_W    = 5
);
    logic [EXEC_LEN-1:0] exec_vld;
    logic                jump_true;
    logic                jump_false;
    logic                mem_req;
    logic                csr_vld;
    logic [11:0]         csr_addr;
    logic                rearm;
    logic [SEL_W-1:0]    rd_sel;
    logic [CNT_W-1:0]    rd_data;
    logic                running;
    logic                done;
    logic                ovf;

    modport master (
        output exec_vld, jump_true, jump_false, mem_req,
        output csr_vld, csr_addr, rearm, rd_sel,
        input  rd_data, running, done, ovf
    );

    modport slave (
        input  exec_vld, jump_true, jump_false, mem_req,
        input  csr_vld, csr_addr, rearm, rd_sel,
        output rd_data, running, done, ovf
    );
endinterface

// File: rtl/ssrv_perf_mon.sv
// Benchmark performance monitor: CSR-triggered window, saturating event counters, registered readback.
// Define PERF_HIST_EN to build the per-cycle retire-width histogram (rd_sel 5..5+EXEC_LEN).
module ssrv_perf_mon #(
    parameter int EXEC_LEN = 4,
    parameter int CNT_W    = 32,
    parameter int SEL_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    ssrv_perf_mon_if.slave     bus
);

    localparam int PC_W = $clog2(EXEC_LEN + 1);

    if (EXEC_LEN < 1 || EXEC_LEN > 8) begin : g_bad_exec_len
        $error("ssrv_perf_mon: EXEC_LEN must be 1..8");
    end
    if (CNT_W < 16 || CNT_W > 64) begin : g_bad_cnt_w
        $error("ssrv_perf_mon: CNT_W must be 16..64");
    end
    if ((1 << SEL_W) < EXEC_LEN + 6) begin : g_bad_sel_w
        $error("ssrv_perf_mon: SEL_W too narrow for the counter map");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [PC_W-1:0] popcount(input logic [EXEC_LEN-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < EXEC_LEN; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    // MSB of the result flags that the true sum did not fit and was clamped.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, inc};
        if (s[CNT_W]) begin
            s = {1'b1, {CNT_W{1'b1}}};
        end
        return s;
    endfunction

    state_t           state;
    logic             running_r;
    logic             done_r;
    logic             ovf_r;
    logic             trig;
    logic             start;
    logic             count_en;
    logic [PC_W-1:0]  retire_cnt;

    logic [CNT_W-1:0] ticks;
    logic [CNT_W-1:0] instr;
    logic [CNT_W-1:0] jtrue;
    logic [CNT_W-1:0] jfalse;
    logic [CNT_W-1:0] mem;

    logic [CNT_W:0]   ticks_s;
    logic [CNT_W:0]   instr_s;
    logic [CNT_W:0]   jtrue_s;
    logic [CNT_W:0]   jfalse_s;
    logic [CNT_W:0]   mem_s;
    logic             hist_sat;
    logic             any_sat;

    logic [CNT_W-1:0] rd_mux_p0;
    logic [CNT_W-1:0] rd_data_p1;

    assign trig = bus.csr_vld &
                  ((bus.csr_addr == 12'hC00) |
                   (bus.csr_addr == 12'hC01) |
                   (bus.csr_addr == 12'hC80));

    assign start      = (state == S_IDLE) & trig;
    assign count_en   = (state == S_RUN);
    assign retire_cnt = popcount(bus.exec_vld);

    // Window control; trig in DONE is ignored, rearm takes priority there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (trig) begin
                        state     <= S_RUN;
                        running_r <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (trig) begin
                        state     <= S_DONE;
                        running_r <= 1'b0;
                        done_r    <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.rearm) begin
                        state  <= S_IDLE;
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    running_r <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ticks_s  = sat_add(ticks,  CNT_W'(1));
        instr_s  = sat_add(instr,  CNT_W'(retire_cnt));
        jtrue_s  = sat_add(jtrue,  CNT_W'(bus.jump_true));
        jfalse_s = sat_add(jfalse, CNT_W'(bus.jump_false));
        mem_s    = sat_add(mem,    CNT_W'(bus.mem_req));
        any_sat  = ticks_s[CNT_W] | instr_s[CNT_W] | jtrue_s[CNT_W] |
                   jfalse_s[CNT_W] | mem_s[CNT_W] | hist_sat;
    end

    // Counters are cleared only by reset or a start; IDLE keeps the last window readable.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            ticks  <= '0;
            instr  <= '0;
            jtrue  <= '0;
            jfalse <= '0;
            mem    <= '0;
            ovf_r  <= 1'b0;
        end else if (count_en) begin
            ticks  <= ticks_s[CNT_W-1:0];
            instr  <= instr_s[CNT_W-1:0];
            jtrue  <= jtrue_s[CNT_W-1:0];
            jfalse <= jfalse_s[CNT_W-1:0];
            mem    <= mem_s[CNT_W-1:0];
            ovf_r  <= ovf_r | any_sat;
        end
    end

`ifdef PERF_HIST_EN
    logic [CNT_W-1:0] hist   [EXEC_LEN+1];
    logic [CNT_W:0]   hist_s [EXEC_LEN+1];

    always_comb begin
        hist_sat = 1'b0;
        for (int k = 0; k <= EXEC_LEN; k++) begin
            hist_s[k] = sat_add(hist[k], CNT_W'(retire_cnt == PC_W'(k)));
            hist_sat  = hist_sat | hist_s[k][CNT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            for (int k = 0; k <= EXEC_LEN; k++) begin
                hist[k] <= '0;
            end
        end else if (count_en) begin
            for (int k = 0; k <= EXEC_LEN; k++) begin
                hist[k] <= hist_s[k][CNT_W-1:0];
            end
        end
    end
`else
    assign hist_sat = 1'b0;
`endif

    // Readback stage 0: select from the counters as they stand after the last edge.
    always_comb begin
        rd_mux_p0 = '0;
        case (bus.rd_sel)
            SEL_W'(0): rd_mux_p0 = ticks;
            SEL_W'(1): rd_mux_p0 = instr;
            SEL_W'(2): rd_mux_p0 = jtrue;
            SEL_W'(3): rd_mux_p0 = jfalse;
            SEL_W'(4): rd_mux_p0 = mem;
            default:   rd_mux_p0 = '0;
        endcase
`ifdef PERF_HIST_EN
        for (int k = 0; k <= EXEC_LEN; k++) begin
            if (bus.rd_sel == SEL_W'(5 + k)) begin
                rd_mux_p0 = hist[k];
            end
        end
`endif
    end

    // Readback stage 1: registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_p1 <= '0;
        end else begin
            rd_data_p1 <= rd_mux_p0;
        end
    end

    assign bus.rd_data = rd_data_p1;
    assign bus.running = running_r;
    assign bus.done    = done_r;
    assign bus.ovf     = ovf_r;

endmodule

// File: tb/tb_ssrv_perf_mon.sv
// Bench for ssrv_perf_mon: table-driven counter readback through a scoreboard queue plus window corner cases.
`timescale 1ns/1ps
module tb_ssrv_perf_mon;

    localparam int EXEC_LEN = 4;
    localparam int CNT_W    = 16;
    localparam int SEL_W    = 5;
`ifdef PERF_HIST_EN
    localparam bit HIST_ON = 1'b1;
`else
    localparam bit HIST_ON = 1'b0;
`endif

    typedef struct {
        int               grp;
        logic [SEL_W-1:0] sel;
        logic [CNT_W-1:0] exp;
        string            name;
    } vec_t;

    typedef struct {
        string            name;
        logic [CNT_W-1:0] exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec;
    int   n_err;
    vec_t vecs[$];
    sb_t  sb_q[$];

    always #5 clk = ~clk;

    ssrv_perf_mon_if #(.EXEC_LEN(EXEC_LEN), .CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

    ssrv_perf_mon #(.EXEC_LEN(EXEC_LEN), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic void add_vec(input int g, input int sel, input int exp, input string n);
        vec_t v;
        v.grp  = g;
        v.sel  = SEL_W'(sel);
        v.exp  = CNT_W'(exp);
        v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic read_check(input int sel, input int exp, input string name);
        sb_t e;
        bus.rd_sel = SEL_W'(sel);
        e.name = name;
        e.exp  = CNT_W'(exp);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check(e.name, bus.rd_data, e.exp);
        @(negedge clk);
    endtask

    task automatic run_table(input int g);
        foreach (vecs[i]) begin
            if (vecs[i].grp == g) begin
                read_check(int'(vecs[i].sel), int'(vecs[i].exp), vecs[i].name);
            end
        end
    endtask

    task automatic idle_inputs();
        bus.exec_vld   = '0;
        bus.jump_true  = 1'b0;
        bus.jump_false = 1'b0;
        bus.mem_req    = 1'b0;
        bus.csr_vld    = 1'b0;
        bus.csr_addr   = 12'h000;
        bus.rearm      = 1'b0;
    endtask

    task automatic pulse_csr(input logic [11:0] addr);
        bus.csr_vld  = 1'b1;
        bus.csr_addr = addr;
        @(negedge clk);
        bus.csr_vld  = 1'b0;
    endtask

    task automatic pulse_rearm();
        bus.rearm = 1'b1;
        @(negedge clk);
        bus.rearm = 1'b0;
    endtask

    task automatic check_status(input string tag, input bit run, input bit dn, input bit ov);
        check({tag, "_running"}, CNT_W'(bus.running), CNT_W'(run));
        check({tag, "_done"},    CNT_W'(bus.done),    CNT_W'(dn));
        check({tag, "_ovf"},     CNT_W'(bus.ovf),     CNT_W'(ov));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;

        for (int s = 0; s <= 4; s++) add_vec(1, s, 0, $sformatf("rst_sel%0d", s));

        add_vec(2, 0, 11, "w1_ticks");
        add_vec(2, 1, 33, "w1_instr");
        add_vec(2, 2, 0,  "w1_jtrue");
        add_vec(2, 3, 0,  "w1_jfalse");
        add_vec(2, 4, 6,  "w1_mem");
        add_vec(2, 5, 0,  "w1_hist0");
        add_vec(2, 6, 0,  "w1_hist1");
        add_vec(2, 7, 0,  "w1_hist2");
        add_vec(2, 8, HIST_ON ? 11 : 0, "w1_hist3");
        add_vec(2, 9, 0,  "w1_hist4");
        add_vec(2, 10, 0, "w1_sel10");
        add_vec(2, 31, 0, "w1_sel31");

        add_vec(3, 0, 7, "w2_ticks");
        add_vec(3, 1, 7, "w2_instr");
        add_vec(3, 2, 3, "w2_jtrue");
        add_vec(3, 3, 2, "w2_jfalse");
        add_vec(3, 4, 0, "w2_mem");
        add_vec(3, 5, 0, "w2_hist0");
        add_vec(3, 6, HIST_ON ? 7 : 0, "w2_hist1");

        idle_inputs();
        bus.rd_sel = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_status("reset", 1'b0, 1'b0, 1'b0);
        run_table(1);

        // Window 1: start-trigger cycle carries events that must not count.
        for (int c = 0; c <= 11; c++) begin
            bus.exec_vld = 4'b1011;
            bus.mem_req  = (c % 2 == 1) || (c == 0);
            bus.csr_vld  = (c == 0) || (c == 11);
            bus.csr_addr = (c == 0) ? 12'hC00 : 12'hC80;
            @(negedge clk);
            if (c == 0) check("w1_running_after_start", CNT_W'(bus.running), CNT_W'(1));
        end
        idle_inputs();
        check_status("w1_stop", 1'b0, 1'b1, 1'b0);
        run_table(2);

        pulse_rearm();
        check_status("rearm", 1'b0, 1'b0, 1'b0);
        read_check(0, 11, "idle_hold_ticks");
        read_check(4, 6,  "idle_hold_mem");

        // Window 2: branch events plus a non-trigger CSR access mid-window.
        for (int c = 0; c <= 7; c++) begin
            bus.exec_vld   = (c >= 1) ? 4'b0001 : 4'b0000;
            bus.jump_true  = (c >= 1) && (c <= 3);
            bus.jump_false = (c == 4) || (c == 5);
            bus.csr_vld    = (c == 0) || (c == 6) || (c == 7);
            bus.csr_addr   = (c == 0) ? 12'hC01 : ((c == 6) ? 12'h300 : 12'hC00);
            @(negedge clk);
            if (c == 6) begin
                check("csr300_running", CNT_W'(bus.running), CNT_W'(1));
                check("csr300_done",    CNT_W'(bus.done),    CNT_W'(0));
            end
        end
        idle_inputs();
        check_status("w2_stop", 1'b0, 1'b1, 1'b0);
        run_table(3);

        // rearm and trig together in DONE: back to IDLE, no new window.
        bus.rearm    = 1'b1;
        bus.csr_vld  = 1'b1;
        bus.csr_addr = 12'hC00;
        @(negedge clk);
        idle_inputs();
        check_status("rearm_trig", 1'b0, 1'b0, 1'b0);
        read_check(0, 7, "rearm_trig_ticks");
        read_check(2, 3, "rearm_trig_jtrue");
        pulse_csr(12'hC00);
        check("restart_running", CNT_W'(bus.running), CNT_W'(1));
        read_check(0, 0, "restart_ticks_clr");
        read_check(2, 0, "restart_jtrue_clr");
        read_check(0, 2, "restart_ticks_cnt");
        pulse_csr(12'hC80);
        pulse_rearm();

        // Saturation window.
        pulse_csr(12'hC00);
        bus.exec_vld = 4'b1111;
        repeat (70000) @(negedge clk);
        pulse_csr(12'hC80);
        idle_inputs();
        check_status("sat_stop", 1'b0, 1'b1, 1'b1);
        read_check(0, 16'hFFFF, "sat_ticks");
        read_check(1, 16'hFFFF, "sat_instr");
        read_check(2, 0, "sat_jtrue");
        read_check(9, HIST_ON ? 16'hFFFF : 0, "sat_hist4");
        read_check(8, 0, "sat_hist3");
        pulse_rearm();
        check("ovf_hold_idle", CNT_W'(bus.ovf), CNT_W'(1));
        pulse_csr(12'hC00);
        check("ovf_clr_start", CNT_W'(bus.ovf), CNT_W'(0));
        read_check(0, 0, "sat_restart_ticks");
        read_check(1, 0, "sat_restart_instr");

        // Reset mid-window.
        bus.exec_vld = 4'b1111;
        bus.mem_req  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        check_status("midrst", 1'b0, 1'b0, 1'b0);
        check("midrst_rd_data", bus.rd_data, CNT_W'(0));
        read_check(1, 0, "midrst_instr");
        read_check(4, 0, "midrst_mem");
        pulse_csr(12'hC01);
        check("fresh_running", CNT_W'(bus.running), CNT_W'(1));
        repeat (2) @(negedge clk);
        pulse_csr(12'hC00);
        check("fresh_done", CNT_W'(bus.done), CNT_W'(1));
        read_check(0, 3, "fresh_ticks");

        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
